// File: rtl/avalon_wb_bridge.sv
// Registered Avalon-MM slave to Wishbone B3 classic master, one transfer at a time.
// Define AVB_WB_TIMEOUT_EN to abort stalled Wishbone cycles after TIMEOUT cycles.
module avalon_wb_bridge #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   address,
  input  logic            chipselect,
  input  logic            read,
  input  logic            write,
  input  logic [DW-1:0]   writedata,
  input  logic [DW/8-1:0] byteenable,
  output logic            waitrequest,
  output logic [DW-1:0]   readdata,
  output logic [1:0]      response,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  if ((DW % 8) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("avalon_wb_bridge: DW must be a multiple of 8, TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic conflict;
  logic fin_ack;
  logic fin_err;
  logic fin_to;

  assign accept   = chipselect & (read ^ write);
  assign conflict = chipselect & read & write;
  assign fin_ack  = wb_ack_i;
  assign fin_err  = ~wb_ack_i & wb_err_i;

`ifdef AVB_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;

  // Held at zero outside BUS, so it is clear on entry to BUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != BUS) begin
      to_cnt <= '0;
    end else if (!wb_ack_i && !wb_err_i) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign fin_to = ~wb_ack_i & ~wb_err_i &
                  (to_cnt == CW'(TIMEOUT - 1));
`else
  assign fin_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUS;
        end else if (conflict) begin
          state_nxt = DONE;
        end
      end
      BUS: begin
        if (fin_ack || fin_err || fin_to) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cyc/stb decode straight from the state flops, so they are glitch-free.
  always_comb begin
    waitrequest = (state != DONE);
    wb_cyc_o    = (state == BUS);
    wb_stb_o    = (state == BUS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      readdata <= '0;
      response <= RESP_OKAY;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          wb_adr_o <= address;
          wb_dat_o <= writedata;
          wb_sel_o <= byteenable;
          wb_we_o  <= write;
        end else if (conflict) begin
          response <= RESP_SLVERR;
        end
      end
      if (state == BUS) begin
        if (fin_ack) begin
          response <= RESP_OKAY;
          if (!wb_we_o) begin
            readdata <= wb_dat_i;
          end
        end else if (fin_err) begin
          response <= RESP_SLVERR;
        end else if (fin_to) begin
          response <= RESP_DECERR;
          if (!wb_we_o) begin
            readdata <= {DW{1'b1}};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_wb_bridge.sv
// Directed bench for avalon_wb_bridge.
// Timeout steps depend on whether AVB_WB_TIMEOUT_EN is defined.
module tb_avalon_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  response;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  avalon_wb_bridge #(.AW(5), .DW(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .byteenable (byteenable),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .response   (response),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  int          done_cyc;
  int          cyc_cnt;
  logic        cyc1;
  logic        stb1;
  logic [4:0]  adr1;
  logic [3:0]  sel1;
  logic        we1;
  logic [31:0] dat1;
  logic        wr_after;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one command at cycle 0; slave answers in cycle n_ack
  // (mode 0 ack, 1 err, 2 ack+err). done_cyc = waitrequest-low cycle.
  task automatic xfer(input logic rd, input logic wr,
                      input logic [4:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int n_ack,
                      input int mode, input logic [31:0] rdat,
                      input int max_c);
    chipselect = 1'b1;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = wd;
    byteenable = be;
    done_cyc   = -1;
    cyc_cnt    = 0;
    for (int c = 1; c <= max_c && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) cyc_cnt++;
      if (c == 1) begin
        cyc1 = wb_cyc_o;
        stb1 = wb_stb_o;
        adr1 = wb_adr_o;
        sel1 = wb_sel_o;
        we1  = wb_we_o;
        dat1 = wb_dat_o;
      end
      if (!waitrequest) begin
        done_cyc   = c;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
      end else if (c == n_ack) begin
        wb_ack_i = (mode != 1);
        wb_err_i = (mode != 0);
        wb_dat_i = rdat;
      end
    end
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    @(posedge clk); #1;
    wr_after = waitrequest;
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    wb_dat_i   = '0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait", waitrequest, 1);
    check("rst_resp", response, 0);
    check("rst_rdata", readdata, 0);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel_o, 0);
    check("rst_we", wb_we_o, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: write, slave acks one cycle after stb
    xfer(1'b0, 1'b1, 5'd3, 32'h0000_00A5, 4'b0001, 2, 0, 32'h0, 40);
    check("w_cyc1", cyc1, 1);
    check("w_stb1", stb1, 1);
    check("w_adr", adr1, 3);
    check("w_sel", sel1, 4'b0001);
    check("w_we", we1, 1);
    check("w_dat", dat1, 32'h0000_00A5);
    check("w_done", done_cyc, 3);
    check("w_cyccnt", cyc_cnt, 2);
    check("w_resp", response, 0);
    check("w_after", wr_after, 1);
    check("w_rdata", readdata, 0);

    // 2: reads, then a write that must not touch readdata
    xfer(1'b1, 1'b0, 5'd5, 32'h0, 4'hF, 2, 0, 32'h1234_5678, 40);
    check("r_we", we1, 0);
    check("r_adr", adr1, 5);
    check("r_done", done_cyc, 3);
    check("r_rdata", readdata, 32'h1234_5678);
    check("r_resp", response, 0);
    check("r_after", wr_after, 1);
    xfer(1'b1, 1'b0, 5'd7, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D, 40);
    check("r1_done", done_cyc, 2);
    check("r1_rdata", readdata, 32'hCAFE_F00D);
    xfer(1'b0, 1'b1, 5'd1, 32'hFFFF_0000, 4'hF, 1, 0, 32'hDEAD_BEEF, 40);
    check("w2_dat", dat1, 32'hFFFF_0000);
    check("w2_sel", sel1, 4'hF);
    check("w2_rdata", readdata, 32'hCAFE_F00D);

    // 3: error response, then ack+err together
    xfer(1'b1, 1'b0, 5'd9, 32'h0, 4'hF, 2, 1, 32'h1111_1111, 40);
    check("e_done", done_cyc, 3);
    check("e_resp", response, 2'b10);
    check("e_rdata", readdata, 32'hCAFE_F00D);
    xfer(1'b1, 1'b0, 5'd9, 32'h0, 4'hF, 2, 2, 32'h0BAD_C0DE, 40);
    check("ae_resp", response, 0);
    check("ae_rdata", readdata, 32'h0BAD_C0DE);

    // 4: read and write together
    xfer(1'b1, 1'b1, 5'd4, 32'h0, 4'hF, 0, 0, 32'h0, 40);
    check("rw_done", done_cyc, 1);
    check("rw_nocyc", cyc_cnt, 0);
    check("rw_resp", response, 2'b10);
    check("rw_after", wr_after, 1);
    check("rw_rdata", readdata, 32'h0BAD_C0DE);

    // 5: stalled slave
`ifdef AVB_WB_TIMEOUT_EN
    xfer(1'b0, 1'b1, 5'd2, 32'h5A5A_5A5A, 4'hF, 0, 0, 32'h0, 40);
    check("tw_done", done_cyc, 9);
    check("tw_cyccnt", cyc_cnt, 8);
    check("tw_resp", response, 2'b11);
    check("tw_rdata", readdata, 32'h0BAD_C0DE);
    xfer(1'b1, 1'b0, 5'd2, 32'h0, 4'hF, 0, 0, 32'h0, 40);
    check("tr_done", done_cyc, 9);
    check("tr_cyccnt", cyc_cnt, 8);
    check("tr_resp", response, 2'b11);
    check("tr_rdata", readdata, 32'hFFFF_FFFF);
    xfer(1'b1, 1'b0, 5'd2, 32'h0, 4'hF, 8, 0, 32'h7777_0001, 40);
    check("tack_done", done_cyc, 9);
    check("tack_resp", response, 0);
    check("tack_rdata", readdata, 32'h7777_0001);
`else
    xfer(1'b1, 1'b0, 5'd2, 32'h0, 4'hF, 1001, 0, 32'h7777_0001, 1100);
    check("nt_cyccnt", cyc_cnt, 1001);
    check("nt_done", done_cyc, 1002);
    check("nt_resp", response, 0);
    check("nt_rdata", readdata, 32'h7777_0001);
`endif

    // 6: reset while the Wishbone cycle is open
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 5'd2;
    @(posedge clk); #1;
    check("mr_cyc_pre", wb_cyc_o, 1);
    #2 reset = 1'b1;
    #1;
    check("mr_cyc", wb_cyc_o, 0);
    check("mr_stb", wb_stb_o, 0);
    check("mr_wait", waitrequest, 1);
    check("mr_resp", response, 0);
    check("mr_rdata", readdata, 0);
    chipselect = 1'b0;
    read       = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1'b1, 1'b0, 5'd6, 32'h0, 4'b0011, 2, 0, 32'h600D_F00D, 40);
    check("mr_adr", adr1, 6);
    check("mr_sel", sel1, 4'b0011);
    check("mr_done", done_cyc, 3);
    check("mr_rd2", readdata, 32'h600D_F00D);
    check("mr_resp2", response, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
